sprite_line_fetcher: RTL
========================

// Module: sprite_line_fetcher
// PURPOSE
//  Downstream consumer of the sprite RAM's 16-bit VGA-side port (2048 x 16 words, RGB565).
//  - Each line_start: fetches one 32-pixel sprite row from that port into a local line buffer.
//  - During active video: delivers a per-pixel colour plus a hit flag to the VGA colour mux.
//  - Key colour is treated as transparent.
// PARAMETERS
//  SPR_W        32        sprite width in pixels = words fetched per line
//  SPR_H        32        sprite height in lines
//  FRAME_WORDS  1024      words per animation frame (SPR_W*SPR_H)
//  TRANSPARENT  16'hF81F  RGB565 colour that never produces a hit
// PORTS
//  clk           in   1   single clock, also drives the RAM's VGA-side port
//  reset         in   1   synchronous, active-high
//  line_start    in   1   1-cycle pulse at start of hblank preceding line next_y
//  next_y        in   10  line about to be displayed
//  sprite_x      in   10  sprite left column
//  sprite_y      in   10  sprite top line
//  sprite_en     in   1   sprite visible
//  frame_sel     in   1   animation frame 0/1
//  ram_address   out  11  word address to sprite RAM port 2
//  ram_chipselect out 1   high while fetching
//  ram_readdata  in   16  RAM port 2 data; valid 1 cycle after ram_address is sampled
//  draw_x        in   10  current pixel column
//  pixel_valid   in   1   active-video qualifier for draw_x
//  pix_color     out  16  sprite pixel colour
//  pix_hit       out  1   opaque sprite pixel at draw_x
//  busy          out  1   fetch in progress
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, row_valid=0, latched x/frame=0; buffer contents don't-care.
//  States:
//  - IDLE.
//  - FETCH: SPR_W cycles, col 0..SPR_W-1.
//  - DRAIN: 1 cycle, last word written.
//  - Then back to IDLE.
//  line_start (any state, including FETCH/DRAIN = abort and restart):
//  - Latch sprite_x->lx and frame_sel->lf.
//  - row = next_y - sprite_y, 10-bit unsigned wrap.
//  - row_valid <= sprite_en && row < SPR_H.
//  - If row_valid: go to FETCH with col=0; else go to IDLE.
//  FETCH:
//  - ram_address = lf*FRAME_WORDS + row*SPR_W + col; ram_chipselect=1; busy=1.
//  - Data for col k arrives the next cycle and is written to buffer[k].
//  - Fetch completes SPR_W+1 cycles after line_start.
//  - An abort discards the in-flight word, and row_valid reflects the new line.
//  Display path, registered, 1-cycle latency (pix_* at cycle t+1 reflect draw_x at t):
//  - c = draw_x - lx, 10-bit unsigned.
//  - pix_hit <= pixel_valid && row_valid && !busy && c < SPR_W && buffer[c] != TRANSPARENT.
//  - pix_color <= buffer[c] when hit, else 0.
//  Boundaries:
//  - Sprite straddling the right edge: columns >= 640 are never driven; no horizontal wrap (c >= SPR_W means no hit).
//  - sprite_y > next_y: wrapped row >= SPR_H, so no fetch.
//  - row = SPR_H-1 is the last valid line.
//  - pixel_valid low forces pix_hit=0.
//  Integrator rule: line_start must precede the first active pixel by >= SPR_W+2 cycles.
// STRUCTURE
//  sprite_pkg:
//  - SPR_W, SPR_H, FRAME_WORDS, TRANSPARENT.
//  - fetch state enum {IDLE, FETCH, DRAIN}.
//  - RGB565 pixel typedef.
//  Sub-module sprite_line_buf:
//  - SPR_W x 16 register array.
//  - One synchronous write port (fetch) and one asynchronous read port (display).
//  Top level: FSM, address generator, display compare/register.
// TESTING
//  1 reset mid-FETCH -> next cycle busy=0, ram_chipselect=0, pix_hit=0, pix_color=0.
//  2 sprite_y=100, next_y=100, x=200, frame 0:
//    - ram_address 0..31 on consecutive cycles, busy for 33 cycles.
//    - draw_x=200..231 -> pix_color = RAM[0..31] one cycle later.
//  3 frame_sel=1, next_y=131 (row 31) -> addresses 2016..2047; next_y=132 -> no fetch, pix_hit=0.
//  4 word = 16'hF81F at col 5 -> pix_hit=0 at draw_x=lx+5; neighbours hit.
//  5 sprite_x=620 -> hits only for draw_x 620..639; draw_x=0..11 never hit (no wrap).
//  6 line_start again at FETCH col 10 -> restart at new row's col 0, no stale write.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite line fetcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int SPR_W       = 32;
    localparam int SPR_H       = 32;
    localparam int FRAME_WORDS = SPR_W * SPR_H;
    localparam int COL_W       = $clog2(SPR_W);
    localparam int ROW_W       = $clog2(SPR_H);

    localparam logic [15:0] TRANSPARENT = 16'hF81F;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/sprite_line_buf.sv
// One sprite row of RGB565 pixels: synchronous write from fetch, async read for display.
// Latency: write visible on the cycle after wr_en; read is combinational.
// Backpressure: none, the write port accepts every cycle.
module sprite_line_buf
    import sprite_pkg::*;
(
    input  logic        clk,
    input  logic        wr_en,
    input  logic [4:0]  wr_idx,
    input  logic [15:0] wr_dat,
    input  logic [4:0]  rd_idx,
    output logic [15:0] rd_dat
);

    rgb565_t mem_q [SPR_W];
    rgb565_t mem_d [SPR_W];

    // Next buffer contents: unchanged except the written entry.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_dat;
        end
    end

    // Buffer storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/sprite_line_fetcher.sv
// Fetches one 32-pixel sprite row per line_start and serves per-pixel colour/hit to the VGA mux.
// Latency: fetch done SPR_W+1 cycles after line_start; pixel path is 1 cycle after draw_x.
// Backpressure: none; a new line_start aborts any fetch in progress and restarts.
module sprite_line_fetcher
    import sprite_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [9:0]  next_y,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic        sprite_en,
    input  logic        frame_sel,
    output logic [10:0] ram_address,
    output logic        ram_chipselect,
    input  logic [15:0] ram_readdata,
    input  logic [9:0]  draw_x,
    input  logic        pixel_valid,
    output logic [15:0] pix_color,
    output logic        pix_hit,
    output logic        busy
);

    fetch_state_e     state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [9:0]       lx_q, lx_d;
    logic             lf_q, lf_d;
    logic             row_valid_q, row_valid_d;

    // Tracks the word whose address went out last cycle and lands this cycle.
    logic             wr_vld_q, wr_vld_d;
    logic [COL_W-1:0] wr_idx_q, wr_idx_d;

    logic             pix_hit_q, pix_hit_d;
    rgb565_t          pix_color_q, pix_color_d;

    logic [9:0]       row_full;
    logic             row_ok;
    logic [9:0]       c_full;
    logic             buf_wr_en;
    rgb565_t          buf_rd_dat;

    assign row_full = next_y - sprite_y;
    assign row_ok   = sprite_en && (row_full < 10'(SPR_H));
    assign c_full   = draw_x - lx_q;

    // A word arriving in a line_start cycle belongs to the old row, so drop it.
    assign buf_wr_en = wr_vld_q && !line_start;

    sprite_line_buf u_line_buf (
        .clk    (clk),
        .wr_en  (buf_wr_en),
        .wr_idx (wr_idx_q),
        .wr_dat (ram_readdata),
        .rd_idx (c_full[COL_W-1:0]),
        .rd_dat (buf_rd_dat)
    );

    // Fetch FSM next state; line_start overrides everything and restarts the row.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        lx_d        = lx_q;
        lf_d        = lf_q;
        row_valid_d = row_valid_q;
        wr_vld_d    = (state_q == FETCH) && !line_start;
        wr_idx_d    = col_q;

        case (state_q)
            FETCH: begin
                if (col_q == COL_W'(SPR_W - 1)) begin
                    state_d = DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (line_start) begin
            lx_d        = sprite_x;
            lf_d        = frame_sel;
            row_d       = row_full[ROW_W-1:0];
            row_valid_d = row_ok;
            col_d       = '0;
            state_d     = row_ok ? FETCH : IDLE;
        end
    end

    // Display compare: column within the sprite, not keyed out, and buffer stable.
    always_comb begin
        pix_hit_d   = pixel_valid && row_valid_q && (state_q == IDLE) &&
                      (c_full < 10'(SPR_W)) && (buf_rd_dat != TRANSPARENT);
        pix_color_d = pix_hit_d ? buf_rd_dat : 16'h0000;
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            lx_q        <= '0;
            lf_q        <= 1'b0;
            row_valid_q <= 1'b0;
            wr_vld_q    <= 1'b0;
            wr_idx_q    <= '0;
            pix_hit_q   <= 1'b0;
            pix_color_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            lx_q        <= lx_d;
            lf_q        <= lf_d;
            row_valid_q <= row_valid_d;
            wr_vld_q    <= wr_vld_d;
            wr_idx_q    <= wr_idx_d;
            pix_hit_q   <= pix_hit_d;
            pix_color_q <= pix_color_d;
        end
    end

    // Address = frame*FRAME_WORDS + row*SPR_W + col, which is a plain concatenation.
    assign ram_chipselect = (state_q == FETCH);
    assign ram_address    = ram_chipselect ? {lf_q, row_q, col_q} : 11'd0;
    assign busy           = (state_q != IDLE);
    assign pix_hit        = pix_hit_q;
    assign pix_color      = pix_color_q;

endmodule
